// File: rtl/graph_delete_modify_pipe.sv
// Multi-lane reconvergent buf/inv/and/or/nand/nor cone feeding a DEPTH-stage
// valid-qualified pipeline with stall, plus a saturating output-change counter.
module graph_delete_modify_pipe #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic             mode,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam int DW = 4 * WIDTH;
  localparam int BW = DW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Packed lane results ordered as the q outputs: {n5, n7, n8, n6}.
  function automatic logic [DW-1:0] lane_cone(
    input logic             m,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] n3, n5, n6, n7, n8;
    n3 = m ? c : ~c;
    n5 = a & b;
    n6 = b | n3;
    n7 = ~(n5 & n6);
    n8 = ~(n5 | n3);
    return {n5, n7, n8, n6};
  endfunction

  logic [BW-1:0]    beat_in_s;
  logic [BW-1:0]    stage_q [DEPTH];
  logic [BW-1:0]    stage_d [DEPTH];
  logic [BW-1:0]    tail_in_s;
  logic             tail_valid_s;
  logic [DW-1:0]    tail_data_s;
  logic [DW-1:0]    last_q;
  logic [DW-1:0]    last_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign beat_in_s = {in_valid, lane_cone(mode, d1, d2, d3)};

  // Shift on enable, otherwise every stage holds its beat.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (en) begin
      stage_d[0] = beat_in_s;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end else begin
      stage_d[0] = stage_q[0];
    end
  end

  // The beat about to land in the last stage is what gets compared and counted.
  assign tail_in_s    = stage_d[DEPTH-1];
  assign tail_valid_s = en & tail_in_s[DW];
  assign tail_data_s  = tail_in_s[DW-1:0];

  // Change counter next state; clear overrides any increment.
  always_comb begin
    last_d = last_q;
    cnt_d  = cnt_q;
    if (tail_valid_s) begin
      last_d = tail_data_s;
      if ((tail_data_s != last_q) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      last_d = last_q;
    end
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_d;
    end
  end

  // Pipeline stages, last-beat register and counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= {BW{1'b0}};
      end
      last_q <= {DW{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_valid            = stage_q[DEPTH-1][DW];
  assign {q1, q2, q3, q4}     = stage_q[DEPTH-1][DW-1:0];
  assign chg_cnt              = cnt_q;

endmodule

// File: tb/tb_graph_delete_modify_pipe.sv
// Scoreboard bench: instance A (DEPTH=2, CNT_W=8) and instance B (DEPTH=1, CNT_W=2).
module tb_graph_delete_modify_pipe;

  logic       clk;
  logic       rst;
  logic       en, in_valid, mode, clr;
  logic [3:0] d1, d2, d3;
  logic       out_valid;
  logic [3:0] q1, q2, q3, q4;
  logic [7:0] chg_cnt;

  logic       b_en, b_in_valid, b_mode, b_clr;
  logic [3:0] b_d1, b_d2, b_d3;
  logic       b_out_valid;
  logic [3:0] b_q1, b_q2, b_q3, b_q4;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;
  int unsigned ecount = 0;

  typedef struct {
    int unsigned due;
    logic        v;
    logic [15:0] q;
    logic [7:0]  c;
  } exp_t;
  exp_t sb[$];

  graph_delete_modify_pipe #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
    .d1(d1), .d2(d2), .d3(d3), .clr(clr), .out_valid(out_valid),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .chg_cnt(chg_cnt)
  );

  graph_delete_modify_pipe #(.WIDTH(4), .DEPTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .in_valid(b_in_valid), .mode(b_mode),
    .d1(b_d1), .d2(b_d2), .d3(b_d3), .clr(b_clr), .out_valid(b_out_valid),
    .q1(b_q1), .q2(b_q2), .q3(b_q3), .q4(b_q4), .chg_cnt(b_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on each enabled edge, either the due beat emerges or out_valid stays low.
  initial begin
    logic adv;
    exp_t e;
    forever begin
      @(posedge clk);
      adv = en & rst;
      if (adv) ecount++;
      @(negedge clk);
      if (adv) begin
        if (sb.size() > 0 && sb[0].due == ecount) begin
          e = sb.pop_front();
          chk("beat", {out_valid, q1, q2, q3, q4, chg_cnt}, {e.v, e.q, e.c});
        end else begin
          chk("idle_valid", {63'd0, out_valid}, 64'd0);
        end
      end
    end
  end

  task automatic beat(input logic v, input logic m, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input bit push, input logic [15:0] eq,
                      input logic [7:0] ec);
    exp_t e;
    @(negedge clk);
    en = 1'b1; in_valid = v; mode = m; d1 = a; d2 = b; d3 = c;
    if (push) begin
      e.due = ecount + 32'd2;
      e.v = v; e.q = eq; e.c = ec;
      sb.push_back(e);
    end
    @(posedge clk);
  endtask

  task automatic bbeat(input logic v, input logic m, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic cl, input logic [15:0] eq,
                       input logic [1:0] ec);
    @(negedge clk);
    b_en = 1'b1; b_in_valid = v; b_mode = m; b_d1 = a; b_d2 = b; b_d3 = c; b_clr = cl;
    @(posedge clk);
    #1;
    chk("b_beat", {b_out_valid, b_q1, b_q2, b_q3, b_q4, b_cnt}, {v, eq, ec});
  endtask

  initial begin
    logic [24:0] snap;
    rst = 1'b0; en = 1'b0; in_valid = 1'b0; mode = 1'b0; clr = 1'b0;
    d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    b_en = 1'b0; b_in_valid = 1'b0; b_mode = 1'b0; b_clr = 1'b0;
    b_d1 = 4'h0; b_d2 = 4'h0; b_d3 = 4'h0;
    #12;
    chk("a_reset", {out_valid, q1, q2, q3, q4, chg_cnt}, 64'd0);
    chk("b_reset", {b_out_valid, b_q1, b_q2, b_q3, b_q4, b_cnt}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic beat, mode switch, then a beat that will be stalled in stage 0.
    beat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA50F, 8'd1);
    beat(1'b1, 1'b1, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA55A, 8'd2);
    beat(1'b1, 1'b0, 4'h3, 4'h5, 4'h6, 1'b1, 16'h1E6D, 8'd3);

    @(negedge clk);
    #1;
    snap = {out_valid, q1, q2, q3, q4, chg_cnt};
    en = 1'b0; in_valid = 1'b1; mode = 1'b1; d1 = 4'h5; d2 = 4'h9; d3 = 4'hC;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("stall_hold", {39'd0, out_valid, q1, q2, q3, q4, chg_cnt}, {39'd0, snap});
    end

    // Stalled beat emerges on the first enabled edge; repeats and a bubble do not count.
    beat(1'b1, 1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 16'h0F0F, 8'd4);
    beat(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0F0F, 8'd4);
    beat(1'b1, 1'b1, 4'h0, 4'h0, 4'hF, 1'b1, 16'h0F0F, 8'd4);
    beat(1'b0, 1'b0, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA50F, 8'd4);
    beat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA50F, 8'd5);
    beat(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0F0F, 8'd5);
    beat(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 16'h0F0F, 8'd5);
    beat(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'd0);

    // Clear on a stalled edge; the last-beat register survives it.
    @(negedge clk);
    en = 1'b0; clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_stalled", {56'd0, chg_cnt}, 64'd0);
    clr = 1'b0;
    beat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA50F, 8'd0);
    beat(1'b1, 1'b0, 4'h3, 4'h5, 4'h6, 1'b1, 16'h1E6D, 8'd1);
    beat(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'd0);
    beat(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 16'h0000, 8'd0);

    // DEPTH=1, CNT_W=2: saturation at 3, then clear beats a differing beat.
    bbeat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA50F, 2'd1);
    bbeat(1'b1, 1'b1, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA55A, 2'd2);
    bbeat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA50F, 2'd3);
    bbeat(1'b1, 1'b1, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA55A, 2'd3);
    bbeat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA50F, 2'd3);
    bbeat(1'b1, 1'b1, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA55A, 2'd0);
    bbeat(1'b1, 1'b1, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA55A, 2'd0);
    bbeat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b0, 16'hA50F, 2'd1);
    @(negedge clk);
    b_en = 1'b0;

    // Asynchronous reset with two valid beats inside the pipeline.
    beat(1'b1, 1'b0, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA50F, 8'd2);
    beat(1'b1, 1'b1, 4'hF, 4'hA, 4'h0, 1'b1, 16'hA55A, 8'd3);
    beat(1'b1, 1'b0, 4'h3, 4'h5, 4'h6, 1'b1, 16'h1E6D, 8'd4);
    @(negedge clk);
    #2;
    sb.delete();
    rst = 1'b0;
    #1;
    chk("a_async_rst", {out_valid, q1, q2, q3, q4, chg_cnt}, 64'd0);
    chk("b_async_rst", {b_out_valid, b_q1, b_q2, b_q3, b_q4, b_cnt}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_quiet", {55'd0, out_valid, chg_cnt}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
